icache_tag_lookup: RTL and testbench

ICACHE_TAG_LOOKUP -- requirements
Module: icache_tag_lookup

---
 rtl/icache_tag_lookup.sv | 125 ++++++++++++
 tb/tb_icache_tag_lookup.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/icache_tag_lookup.sv
// rtl/icache_tag_lookup.sv - flop-based set-associative instruction cache tag array
// One-cycle lookup with a single response slot, miss refill with round-robin victim choice, flush.
module icache_tag_lookup #(
  parameter int XLEN             = 32,
  parameter int SETIDXBITS       = 5,
  parameter int BLOCK_OFFSETBITS = 1,
  parameter int WORD_OFFSETBITS  = 1,
  parameter int NWAYS            = 2,
  parameter int WIDBITS          = 3,
  localparam int TAGBITS = XLEN - SETIDXBITS - BLOCK_OFFSETBITS - WORD_OFFSETBITS,
  localparam int WAYBITS = $clog2(NWAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [WIDBITS-1:0] req_wid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic [WAYBITS-1:0] rsp_way,
  output logic [XLEN-1:0]    rsp_addr,
  output logic [WIDBITS-1:0] rsp_wid,
  input  logic               fill_valid,
  input  logic [XLEN-1:0]    fill_addr,
  output logic [WAYBITS-1:0] fill_way,
  input  logic               flush
);

  localparam int OFFBITS = BLOCK_OFFSETBITS + WORD_OFFSETBITS;
  localparam int NSETS   = 1 << SETIDXBITS;

  logic               valid_q [NSETS][NWAYS];
  logic [TAGBITS-1:0] tag_q   [NSETS][NWAYS];
  logic [WAYBITS-1:0] ptr_q   [NSETS];

  logic [SETIDXBITS-1:0] req_set, fill_set;
  logic [TAGBITS-1:0]    req_tag, fill_tag;
  logic                  lk_hit;
  logic [WAYBITS-1:0]    lk_way;
  logic                  f_match, f_inv, f_use_ptr;
  logic [WAYBITS-1:0]    f_match_way, f_inv_way;
  logic                  unused_fill_offset;

  assign req_set  = req_addr[OFFBITS+SETIDXBITS-1:OFFBITS];
  assign req_tag  = req_addr[XLEN-1:XLEN-TAGBITS];
  assign fill_set = fill_addr[OFFBITS+SETIDXBITS-1:OFFBITS];
  assign fill_tag = fill_addr[XLEN-1:XLEN-TAGBITS];
  assign unused_fill_offset = ^fill_addr[OFFBITS-1:0];

  assign req_ready = !rsp_valid || rsp_ready;

  // Descending scans leave the lowest qualifying way selected.
  always_comb begin
    lk_hit      = 1'b0;
    lk_way      = '0;
    f_match     = 1'b0;
    f_match_way = '0;
    f_inv       = 1'b0;
    f_inv_way   = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][WAYBITS'(w)] && tag_q[req_set][WAYBITS'(w)] == req_tag) begin
        lk_hit = 1'b1;
        lk_way = WAYBITS'(w);
      end
      if (valid_q[fill_set][WAYBITS'(w)] && tag_q[fill_set][WAYBITS'(w)] == fill_tag) begin
        f_match     = 1'b1;
        f_match_way = WAYBITS'(w);
      end
      if (!valid_q[fill_set][WAYBITS'(w)]) begin
        f_inv     = 1'b1;
        f_inv_way = WAYBITS'(w);
      end
    end
  end

  assign f_use_ptr = !f_match && !f_inv;
  assign fill_way  = f_match ? f_match_way : (f_inv ? f_inv_way : ptr_q[fill_set]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        ptr_q[SETIDXBITS'(s)] <= '0;
        for (int w = 0; w < NWAYS; w++) begin
          valid_q[SETIDXBITS'(s)][WAYBITS'(w)] <= 1'b0;
          tag_q[SETIDXBITS'(s)][WAYBITS'(w)]   <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < NSETS; s++) begin
        ptr_q[SETIDXBITS'(s)] <= '0;
        for (int w = 0; w < NWAYS; w++) begin
          valid_q[SETIDXBITS'(s)][WAYBITS'(w)] <= 1'b0;
        end
      end
    end else if (fill_valid) begin
      valid_q[fill_set][fill_way] <= 1'b1;
      tag_q[fill_set][fill_way]   <= fill_tag;
      // Pointer only moves when it actually supplied the victim.
      if (f_use_ptr) begin
        ptr_q[fill_set] <= ptr_q[fill_set] + WAYBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_addr  <= '0;
      rsp_wid   <= '0;
    end else if (req_valid && req_ready) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= lk_hit;
      rsp_way   <= lk_way;
      rsp_addr  <= req_addr;
      rsp_wid   <= req_wid;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_tag_lookup.sv
// tb/tb_icache_tag_lookup.sv - self-checking bench for icache_tag_lookup
// Directed scenarios then random traffic against a behavioural cache model.
module tb_icache_tag_lookup;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [31:0] req_addr, rsp_addr, fill_addr;
  logic [2:0]  req_wid, rsp_wid;
  logic [0:0]  rsp_way, fill_way;
  logic        fill_valid, flush;

  icache_tag_lookup dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wid(req_wid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_addr(rsp_addr), .rsp_wid(rsp_wid),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_way(fill_way), .flush(flush)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 32 sets x 2 ways, tag = addr / 128, set = (addr / 4) % 32.
  bit          m_valid [32][2];
  int unsigned m_tag   [32][2];
  int          m_ptr   [32];
  bit          e_valid, e_hit;
  int          e_way;
  logic [31:0] e_addr;
  logic [2:0]  e_wid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 32; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
    end
  endtask

  task automatic model_lookup(input logic [31:0] a, output bit hit, output int way);
    int s;
    s = (a / 4) % 32;
    hit = 0;
    way = 0;
    for (int w = 1; w >= 0; w--)
      if (m_valid[s][w] && m_tag[s][w] == a / 128) begin
        hit = 1;
        way = w;
      end
  endtask

  task automatic model_victim(input logic [31:0] a, output int way, output bit used_ptr);
    bit hit;
    int s;
    s = (a / 4) % 32;
    model_lookup(a, hit, way);
    used_ptr = 0;
    if (!hit) begin
      if (!m_valid[s][0]) way = 0;
      else if (!m_valid[s][1]) way = 1;
      else begin
        way = m_ptr[s];
        used_ptr = 1;
      end
    end
  endtask

  task automatic step(input bit rv, input logic [31:0] a, input logic [2:0] wid, input bit rr,
                      input bit fv, input logic [31:0] fa, input bit fl);
    bit ready, hit, used_ptr;
    int way, vway, s;
    req_valid = rv; req_addr = a; req_wid = wid; rsp_ready = rr;
    fill_valid = fv; fill_addr = fa; flush = fl;
    #1;
    ready = !e_valid || rr;
    chk("req_ready", {31'b0, req_ready}, {31'b0, ready});
    model_victim(fa, vway, used_ptr);
    chk("fill_way", {31'b0, fill_way}, vway);
    if (rv && ready) begin
      model_lookup(a, hit, way);
      e_valid = 1; e_hit = hit; e_way = way; e_addr = a; e_wid = wid;
    end else if (rr) begin
      e_valid = 0;
    end
    if (fl) model_clear();
    else if (fv) begin
      s = (fa / 4) % 32;
      m_valid[s][vway] = 1;
      m_tag[s][vway] = fa / 128;
      if (used_ptr) m_ptr[s] = (m_ptr[s] + 1) % 2;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
    chk("rsp_hit", {31'b0, rsp_hit}, {31'b0, e_hit});
    chk("rsp_way", {31'b0, rsp_way}, e_way);
    chk("rsp_addr", rsp_addr, e_addr);
    chk("rsp_wid", {29'b0, rsp_wid}, {29'b0, e_wid});
  endtask

  initial begin
    logic [31:0] ra, fa;
    rst = 1'b1;
    req_valid = 0; req_addr = '0; req_wid = '0; rsp_ready = 0;
    fill_valid = 0; fill_addr = '0; flush = 0;
    model_clear();
    e_valid = 0; e_hit = 0; e_way = 0; e_addr = '0; e_wid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset rsp_addr", rsp_addr, 32'd0);
    rst = 1'b0;

    // Cold miss, two fills into set 1, then hit on way 1.
    step(1, 32'h84, 3'd1, 1, 0, 32'h0, 0);
    step(0, 32'h0, 3'd0, 1, 1, 32'h84, 0);
    step(0, 32'h0, 3'd0, 1, 1, 32'h104, 0);
    step(1, 32'h104, 3'd2, 1, 0, 32'h0, 0);
    // Full set: round-robin replacement evicts way 0.
    step(0, 32'h0, 3'd0, 1, 1, 32'h184, 0);
    step(1, 32'h84, 3'd3, 1, 0, 32'h0, 0);
    step(1, 32'h184, 3'd4, 1, 0, 32'h0, 0);
    // Backpressure: hold for 3 cycles, then accept the queued request.
    step(1, 32'h104, 3'd5, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h184, 3'd6, 0, 0, 32'h0, 0);
    step(1, 32'h184, 3'd6, 1, 0, 32'h0, 0);
    // Same-cycle fill and lookup miss, next cycle hit, flush beats fill.
    step(1, 32'h84, 3'd7, 1, 1, 32'h84, 0);
    step(1, 32'h84, 3'd7, 1, 0, 32'h0, 0);
    step(1, 32'h84, 3'd1, 0, 1, 32'h104, 1);
    step(1, 32'h104, 3'd2, 1, 0, 32'h0, 0);
    step(0, 32'h0, 3'd0, 1, 1, 32'h104, 0);
    step(1, 32'h200, 3'd3, 1, 0, 32'h0, 0);
    // Asynchronous reset with a held response.
    step(1, 32'h104, 3'd4, 0, 0, 32'h0, 0);
    req_valid = 0; rsp_ready = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("async rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async req_ready", {31'b0, req_ready}, 32'd1);
    chk("async rsp_addr", rsp_addr, 32'd0);
    model_clear();
    e_valid = 0; e_hit = 0; e_way = 0; e_addr = '0; e_wid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 32'h104, 3'd5, 1, 0, 32'h0, 0);
    step(1, 32'h184, 3'd6, 1, 0, 32'h0, 0);

    // Random traffic over a few sets and tags so hits, evictions and flushes mix.
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fa = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      step(1'($urandom_range(0, 1)), ra, 3'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 3), fa, ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
